// File: rtl/tile_dict_lookup.sv
// Open-addressed tile dictionary lookup with linear probing; result 2*k+1 cycles after accept (k = entries examined).
// One pending slot absorbs a hash offered while busy; a hash offered with the slot full is dropped and sets sticky overflow.
module tile_dict_lookup #(
  parameter int ADDR_W    = 8,
  parameter int IDX_W     = 10,
  parameter int MAX_PROBE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hash_valid,
  input  logic [15:0]       hash_in,
  output logic              hash_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [16+IDX_W:0] wr_data,
  output logic              result_valid,
  output logic              result_hit,
  output logic [IDX_W-1:0]  result_idx,
  output logic [ADDR_W:0]   result_probes,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int ENT_W = 17 + IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_COMPARE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         key_q, key_d;
  logic [ADDR_W:0]     probe_q, probe_d;
  logic                pend_vld_q, pend_vld_d;
  logic [15:0]         pend_hash_q, pend_hash_d;
  logic                fnd_hit_q, fnd_hit_d;
  logic [IDX_W-1:0]    fnd_idx_q, fnd_idx_d;
  logic                res_vld_q, res_vld_d;
  logic                res_hit_q, res_hit_d;
  logic [IDX_W-1:0]    res_idx_q, res_idx_d;
  logic [ADDR_W:0]     res_probes_q, res_probes_d;
  logic                overflow_q, overflow_d;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    rd_data_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic                e_vld;
  logic [15:0]         e_hash;
  logic [IDX_W-1:0]    e_idx;
  logic                accept;
  logic                drop;
  logic                last_probe;

  assign hash_ready = !pend_vld_q;
  assign accept     = hash_valid && hash_ready;
  assign drop       = hash_valid && !hash_ready;

  // Base address is the low bits of the key; the add wraps naturally at DEPTH.
  assign rd_addr    = key_q[ADDR_W-1:0] + probe_q[ADDR_W-1:0];
  assign e_vld      = rd_data_q[ENT_W-1];
  assign e_hash     = rd_data_q[ENT_W-2 -: 16];
  assign e_idx      = rd_data_q[IDX_W-1:0];
  assign last_probe = (probe_q + (ADDR_W+1)'(1)) == (ADDR_W+1)'(MAX_PROBE);

  // Read-before-write: a same-cycle write to the read address returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    probe_d      = probe_q;
    pend_vld_d   = pend_vld_q;
    pend_hash_d  = pend_hash_q;
    fnd_hit_d    = fnd_hit_q;
    fnd_idx_d    = fnd_idx_q;
    res_vld_d    = (state_q == S_DONE);
    res_hit_d    = res_hit_q;
    res_idx_d    = res_idx_q;
    res_probes_d = res_probes_q;
    overflow_d   = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

    if (accept && state_q != S_IDLE) begin
      pend_vld_d  = 1'b1;
      pend_hash_d = hash_in;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          key_d      = pend_hash_q;
          pend_vld_d = 1'b0;
          probe_d    = '0;
          state_d    = S_PROBE;
        end else if (accept) begin
          key_d   = hash_in;
          probe_d = '0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: state_d = S_COMPARE;
      S_COMPARE: begin
        if (e_vld && e_hash == key_q) begin
          fnd_hit_d = 1'b1;
          fnd_idx_d = e_idx;
          state_d   = S_DONE;
        end else if (!e_vld || last_probe) begin
          fnd_hit_d = 1'b0;
          fnd_idx_d = '0;
          state_d   = S_DONE;
        end else begin
          probe_d = probe_q + (ADDR_W+1)'(1);
          state_d = S_PROBE;
        end
      end
      S_DONE: begin
        res_hit_d    = fnd_hit_q;
        res_idx_d    = fnd_idx_q;
        res_probes_d = probe_q + (ADDR_W+1)'(1);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      probe_q      <= '0;
      pend_vld_q   <= 1'b0;
      pend_hash_q  <= '0;
      fnd_hit_q    <= 1'b0;
      fnd_idx_q    <= '0;
      res_vld_q    <= 1'b0;
      res_hit_q    <= 1'b0;
      res_idx_q    <= '0;
      res_probes_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      probe_q      <= probe_d;
      pend_vld_q   <= pend_vld_d;
      pend_hash_q  <= pend_hash_d;
      fnd_hit_q    <= fnd_hit_d;
      fnd_idx_q    <= fnd_idx_d;
      res_vld_q    <= res_vld_d;
      res_hit_q    <= res_hit_d;
      res_idx_q    <= res_idx_d;
      res_probes_q <= res_probes_d;
      overflow_q   <= overflow_d;
    end
  end

  assign result_valid  = res_vld_q;
  assign result_hit    = res_hit_q;
  assign result_idx    = res_idx_q;
  assign result_probes = res_probes_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_tile_dict_lookup.sv
// Bench for tile_dict_lookup: vector table, hand-written corner sequences, randomized lookups vs a dictionary model.
module tb_tile_dict_lookup;
  logic        clk = 1'b0;
  logic        rst;
  logic        hash_valid;
  logic [15:0] hash_in;
  logic        hash_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [26:0] wr_data;
  logic        result_valid;
  logic        result_hit;
  logic [9:0]  result_idx;
  logic [8:0]  result_probes;
  logic        overflow;
  logic        overflow_clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_vld  [256];
  logic [15:0] m_hash [256];
  logic [9:0]  m_idx  [256];

  typedef struct {
    logic        do_wr;
    logic [7:0]  waddr;
    logic [26:0] wdata;
    logic [15:0] hash;
    logic        hit;
    logic [9:0]  idx;
    logic [8:0]  probes;
    int          lat;
  } vec_t;

  tile_dict_lookup #(.ADDR_W(8), .IDX_W(10), .MAX_PROBE(4)) dut (
    .clk(clk), .rst(rst), .hash_valid(hash_valid), .hash_in(hash_in), .hash_ready(hash_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .result_valid(result_valid), .result_hit(result_hit), .result_idx(result_idx),
    .result_probes(result_probes), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] a, input logic [26:0] d);
    m_vld[a]  = d[26];
    m_hash[a] = d[25:10];
    m_idx[a]  = d[9:0];
  endtask

  // Walk up to four consecutive slots from the hash's low byte.
  task automatic ref_lookup(input logic [15:0] h, output logic hit, output logic [9:0] idx,
                            output logic [8:0] probes);
    hit = 1'b0; idx = '0; probes = 9'd4;
    for (int p = 0; p < 4; p++) begin
      logic [7:0] a;
      a = 8'((int'(h[7:0]) + p) % 256);
      if (!m_vld[a]) begin probes = 9'(p + 1); break; end
      if (m_hash[a] == h) begin hit = 1'b1; idx = m_idx[a]; probes = 9'(p + 1); break; end
    end
  endtask

  task automatic write_entry(input logic [7:0] a, input logic [26:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic lookup(input logic [15:0] h, input logic w, input logic [7:0] wa, input logic [26:0] wd,
                        output logic got, output logic hit, output logic [9:0] idx,
                        output logic [8:0] pr, output int lat);
    hash_valid = 1'b1; hash_in = h;
    if (w) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    chk("ready_before_accept", 32'(hash_ready), 32'd1);
    @(posedge clk); #1;
    hash_valid = 1'b0; wr_en = 1'b0;
    if (w) model_write(wa, wd);
    got = 1'b0; hit = 1'b0; idx = '0; pr = '0; lat = 0;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        got = 1'b1; lat = n; hit = result_hit; idx = result_idx; pr = result_probes;
      end
    end
    chk("result_seen", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk); #1;
      chk("valid_one_cycle", 32'(result_valid), 32'd0);
      chk("fields_hold", 32'(result_idx), 32'(idx));
    end
  endtask

  initial begin
    vec_t        tbl [8];
    logic        got, hit, ehit;
    logic [9:0]  idx, eidx;
    logic [8:0]  pr, epr;
    int          lat, cnt;
    logic [9:0]  r_idx [2];
    logic [8:0]  r_pr  [2];

    tbl[0] = '{1'b1, 8'h34, {1'b1, 16'h1234, 10'h05A}, 16'h1234, 1'b1, 10'h05A, 9'd1, 3};
    tbl[1] = '{1'b1, 8'h34, {1'b0, 16'h1234, 10'h05A}, 16'hAB34, 1'b0, 10'h000, 9'd1, 3};
    tbl[2] = '{1'b1, 8'hFF, {1'b1, 16'h00FF, 10'h001}, 16'h00FF, 1'b1, 10'h001, 9'd1, 3};
    tbl[3] = '{1'b1, 8'h00, {1'b1, 16'h11FF, 10'h002}, 16'h11FF, 1'b1, 10'h002, 9'd2, 5};
    tbl[4] = '{1'b1, 8'h01, {1'b1, 16'h22FF, 10'h003}, 16'h22FF, 1'b1, 10'h003, 9'd3, 7};
    tbl[5] = '{1'b1, 8'h02, {1'b1, 16'h44FF, 10'h004}, 16'h33FF, 1'b0, 10'h000, 9'd4, 9};
    tbl[6] = '{1'b0, 8'h00, 27'd0,                     16'h44FF, 1'b1, 10'h004, 9'd4, 9};
    tbl[7] = '{1'b0, 8'h00, 27'd0,                     16'h5501, 1'b0, 10'h000, 9'd3, 7};

    rst = 1'b1; hash_valid = 1'b0; hash_in = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(hash_ready), 32'd1);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_hit", 32'(result_hit), 32'd0);
    chk("rst_idx", 32'(result_idx), 32'd0);
    chk("rst_probes", 32'(result_probes), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 256; a++) write_entry(8'(a), 27'd0);

    foreach (tbl[i]) begin
      if (tbl[i].do_wr) write_entry(tbl[i].waddr, tbl[i].wdata);
      lookup(tbl[i].hash, 1'b0, 8'h00, 27'd0, got, hit, idx, pr, lat);
      chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
      chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(tbl[i].idx));
      chk($sformatf("vec%0d_probes", i), 32'(pr), 32'(tbl[i].probes));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Three back-to-back hashes: two served in order, third dropped; drop beats a same-cycle clear.
    hash_valid = 1'b1; hash_in = 16'h00FF;
    @(posedge clk); #1;
    hash_in = 16'h22FF;
    chk("bp_ready_second", 32'(hash_ready), 32'd1);
    @(posedge clk); #1;
    hash_in = 16'h9999; overflow_clr = 1'b1;
    chk("bp_ready_third", 32'(hash_ready), 32'd0);
    @(posedge clk); #1;
    hash_valid = 1'b0; overflow_clr = 1'b0;
    chk("bp_overflow_set_wins", 32'(overflow), 32'd1);
    cnt = 0; r_idx[0] = '0; r_idx[1] = '0; r_pr[0] = '0; r_pr[1] = '0;
    for (int n = 0; n < 40; n++) begin
      if (result_valid) begin
        if (cnt < 2) begin r_idx[cnt] = result_idx; r_pr[cnt] = result_probes; end
        cnt++;
      end
      @(posedge clk); #1;
    end
    chk("bp_result_count", 32'(cnt), 32'd2);
    chk("bp_first_idx", 32'(r_idx[0]), 32'h001);
    chk("bp_second_idx", 32'(r_idx[1]), 32'h003);
    chk("bp_second_probes", 32'(r_pr[1]), 32'd3);
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    chk("bp_overflow_cleared", 32'(overflow), 32'd0);

    // Entry written alongside the accepted hash lands before the PROBE read.
    lookup(16'h5678, 1'b1, 8'h78, {1'b1, 16'h5678, 10'h2AB}, got, hit, idx, pr, lat);
    chk("wr_during_hit", 32'(hit), 32'd1);
    chk("wr_during_idx", 32'(idx), 32'h2AB);

    // Reset while in COMPARE with a hash waiting in the pending slot.
    hash_valid = 1'b1; hash_in = 16'h00FF;
    @(posedge clk); #1;
    hash_in = 16'h1111;
    @(posedge clk); #1;
    hash_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", 32'(hash_ready), 32'd1);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_hit_cleared", 32'(result_hit), 32'd0);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (result_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_result", 32'(cnt), 32'd0);
    lookup(16'h22FF, 1'b0, 8'h00, 27'd0, got, hit, idx, pr, lat);
    chk("post_rst_idx", 32'(idx), 32'h003);
    chk("post_rst_latency", 32'(lat), 32'd7);

    // Random lookups clustered around the wrap point.
    for (int it = 0; it < 40; it++) begin
      logic [7:0]  a;
      logic [15:0] h;
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        a = 8'((253 + $urandom_range(0, 7)) % 256);
        h = {8'($urandom), 8'((253 + $urandom_range(0, 7)) % 256)};
        write_entry(a, {1'($urandom_range(0, 3) != 0), h, 10'($urandom)});
      end
      a = 8'((253 + $urandom_range(0, 7)) % 256);
      if (m_vld[a] && $urandom_range(0, 1) == 1) h = m_hash[a];
      else h = {8'($urandom), 8'((253 + $urandom_range(0, 7)) % 256)};
      ref_lookup(h, ehit, eidx, epr);
      lookup(h, 1'b0, 8'h00, 27'd0, got, hit, idx, pr, lat);
      chk($sformatf("rnd%0d_hit", it), 32'(hit), 32'(ehit));
      chk($sformatf("rnd%0d_idx", it), 32'(idx), 32'(eidx));
      chk($sformatf("rnd%0d_probes", it), 32'(pr), 32'(epr));
      chk($sformatf("rnd%0d_latency", it), 32'(lat), 32'(2 * int'(epr) + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
